cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus (CDB) arbiter for the Tomasulo core. It collects completed results (tag + 32-bit value) from the functional units, buffers them per unit, and broadcasts exactly one result per clock on the CDB to the register file and all reservation stations. It sits between the adder/multiplier units and every CDB snooper, and it replaces ad-hoc tag/data driving by individual units.

## Interface
Parameters:
- NREQ, 2, number of requesting functional units; index 0 = adder, 1 = multiplier.
- DEPTH, 2, result FIFO entries per requester, power of two, at least 2.
- TAGW, 5, tag width; tag value all-ones (5'b11111) means "no tag / data valid" and is never broadcast.
- DATAW, 32, result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  unit i presents a result.
- req_ready  out  NREQ  FIFO i can accept.
- req_tag  in  NREQ*TAGW  tag of unit i, slice [i*TAGW +: TAGW].
- req_data  in  NREQ*DATAW  result of unit i, slice [i*DATAW +: DATAW].
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_tag  out  TAGW  broadcast tag; all-ones when idle.
- cdb_data  out  DATAW  broadcast value; 0 when idle.
- cdb_src  out  NREQ  one-hot source of the current broadcast; 0 when idle.
- err_bad_tag  out  1  sticky: a request with the all-ones tag was dropped.

## Operation
- Per requester: DEPTH-entry circular FIFO with read/write pointers and a count of width $clog2(DEPTH)+1.
- req_ready[i] = (count_i < DEPTH), combinational from registered count only.
- Push: req_valid[i] & req_ready[i] at the rising edge, with tag != all-ones. A push with the all-ones tag is not enqueued and sets err_bad_tag.
- Arbitration each cycle among FIFOs with count > 0: round-robin starting at pointer rr. The winner's head is popped and loaded into the cdb_* registers. rr becomes (winner+1) mod NREQ. rr is unchanged when nothing is granted.
- No requester pending: cdb_valid=0, cdb_tag=all-ones, cdb_data=0, cdb_src=0.
- The CDB has no back-pressure. A broadcast is consumed in the cycle it is valid.
- Same-cycle push and pop on one FIFO: count unchanged, data ordering preserved (FIFO order per unit).
- Push into an empty FIFO is not visible to the arbiter until the next cycle (no bypass).
- Pop frees space that appears on req_ready the following cycle.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Count never exceeds DEPTH.
- Reset (asynchronous, low): all FIFOs empty, rr=0, err_bad_tag=0, cdb outputs at idle values, req_ready all 1 after deassertion. Reset asserted mid-operation discards all buffered results without broadcasting them.

## Timing
- Latency: a result accepted at edge k is broadcast at the earliest during cycle k+1 (cdb_* registered at edge k+1), if granted.
- Throughput: 1 broadcast per cycle total. Each unit gets at least 1 grant per NREQ cycles while it is pending (round-robin).
- cdb_* and err_bad_tag are registered outputs. req_ready is derived from registered state only (no input-to-output combinational path).
- cdb_valid is high for exactly one cycle per popped entry. Back-to-back broadcasts from the same unit occur only when no other unit is pending.

## Configuration
- CDB_FIXED_PRIO_EN defined: arbitration is fixed priority, highest index wins (multiplier over adder), rr is not implemented, and a lower-index unit can starve.
- CDB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single result: adder pushes tag 8, data 0x00000005 at edge 1 → cycle 2: cdb_valid=1, tag 8, data 5, cdb_src=01; cycle 3 idle (tag 5'b11111, data 0).
- Simultaneous results: adder tag 9/0x11 and multiplier tag 2/0x22 both push at edge 1, rr=0 → cycle 2 adder, cycle 3 multiplier. A repeat with rr=1 → multiplier first.
- Back-pressure: hold the CDB busy with the other unit and push 3 results into adder FIFO (DEPTH=2) → req_ready[0]=0 after 2 pushes, third is not accepted, all results drain in order 10, 11 with no loss or duplication.
- Bad tag: push tag 5'b11111 on the multiplier → nothing broadcast, err_bad_tag=1 until reset.
- Reset mid-operation: both FIFOs full, assert rst for one half-cycle → cdb_valid=0 immediately, no stale broadcast after release, req_ready=11.
- With CDB_FIXED_PRIO_EN: both units continuously pending for 4 cycles → cdb_src=10 on all 4 cycles. Without the macro → alternates 01/10.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-unit result FIFOs feeding a single registered broadcast bus.
// Define CDB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.

module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointers wrap on natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  assign head = mem[rd_ptr];
endmodule

module cdb_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 2,
  parameter int TAGW  = 5,
  parameter int DATAW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*TAGW-1:0]  req_tag,
  input  logic [NREQ*DATAW-1:0] req_data,
  output logic                  cdb_valid,
  output logic [TAGW-1:0]       cdb_tag,
  output logic [DATAW-1:0]      cdb_data,
  output logic [NREQ-1:0]       cdb_src,
  output logic                  err_bad_tag
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = TAGW + DATAW;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][CW-1:0] count;
  logic [NREQ-1:0][RW-1:0] head;
  logic [NREQ-1:0]         pending, push, bad, grant;
  logic [IW-1:0]           gnt_idx, cand;
  logic                    gnt_any;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    logic is_notag;
    assign is_notag     = (req_tag[g*TAGW +: TAGW] == {TAGW{1'b1}});
    assign req_ready[g] = (count[g] < CW'(DEPTH));
    assign pending[g]   = (count[g] != '0);
    assign push[g]      = req_valid[g] & req_ready[g] & ~is_notag;
    assign bad[g]       = req_valid[g] & req_ready[g] & is_notag;

    cdb_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .wdata ({req_tag[g*TAGW +: TAGW], req_data[g*DATAW +: DATAW]}),
      .pop   (grant[g]),
      .head  (head[g]),
      .count (count[g])
    );
  end

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++)
      if (pending[i]) begin
        gnt_idx = IW'(i);
        gnt_any = 1'b1;
      end
  end
`else
  logic [IW-1:0] rr;

  // scan offsets from far to near so the closest pending unit to rr wins
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr) + k) % NREQ);
      if (pending[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rr <= '0;
    else if (gnt_any) rr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  assign grant = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '1;
      cdb_data    <= '0;
      cdb_src     <= '0;
      err_bad_tag <= 1'b0;
    end else begin
      if (gnt_any) begin
        cdb_valid           <= 1'b1;
        {cdb_tag, cdb_data} <= head[gnt_idx];
        cdb_src             <= grant;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= '1;
        cdb_data  <= '0;
        cdb_src   <= '0;
      end
      if (|bad) err_bad_tag <= 1'b1;
    end
  end
endmodule
